// File: rtl/mix_stream_checker_if.sv
// Valid/ready lane-word stream between the mixer output and the checker.
// The producer drives valid/data; the checker drives ready.
interface mix_stream_checker_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mix_stream_checker.sv
// Sink-side checker: regenerates the eight-lane mixing sequence one update per
// cycle and compares each received lane word, counting and localising mismatches.
module mix_stream_checker #(
  parameter int ERR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mix_stream_checker_if.slave  stream,
  input  logic                 clr,
  output logic [ERR_W-1:0]     err_count,
  output logic                 err_flag,
  output logic [31:0]          first_err_round,
  output logic [2:0]           first_err_lane,
  output logic [31:0]          round_count
);

  typedef enum logic {ST_MIX, ST_CMP} state_t;

  localparam logic [31:0] MUL [8] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam logic [31:0] ADD [8] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};

  state_t      state;
  logic [1:0]  phase;
  logic [2:0]  lane;
  logic [31:0] s [8];
  logic        ready_q;

  logic [2:0]  lane_prv;
  logic [2:0]  lane_fwd;
  logic [31:0] cur;
  logic [31:0] prv;
  logic [31:0] fwd;
  logic [31:0] upd;
  logic        hs;
  logic        mism;

  assign stream.in_ready = ready_q;

  // Neighbour lanes wrap naturally in 3 bits: (i+7)%8 == i-1, (i+3)%8 == i+3.
  assign lane_prv = lane - 3'd1;
  assign lane_fwd = lane + 3'd3;
  assign cur      = s[lane];
  assign prv      = s[lane_prv];
  assign fwd      = s[lane_fwd];

  assign hs   = stream.in_valid & ready_q;
  assign mism = hs && (stream.in_data != cur);

  always_comb begin
    // NOTE: upd gets a default before the case so no path leaves it unassigned (no latch).
    upd = cur;
    case (phase)
      2'd0:    upd = cur + prv;
      2'd1:    upd = cur ^ {fwd[15:0], 16'h0000};
      default: upd = cur * MUL[lane] + ADD[lane];
    endcase
  end

  // Mixing engine and stream sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the lane registers hold the seed, so unlike a plain data store they must be reset.
      for (int i = 0; i < 8; i++) s[i] <= 32'(i);
      state       <= ST_MIX;
      phase       <= 2'd0;
      lane        <= 3'd0;
      ready_q     <= 1'b0;
      round_count <= 32'd0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every read sees pre-edge values.
      case (state)
        ST_MIX: begin
          s[lane] <= upd;
          lane    <= lane + 3'd1;
          if (lane == 3'd7) begin
            if (phase == 2'd2) begin
              phase   <= 2'd0;
              state   <= ST_CMP;
              ready_q <= 1'b1;
            end else begin
              phase <= phase + 2'd1;
            end
          end
        end
        ST_CMP: begin
          if (hs) begin
            lane <= lane + 3'd1;
            if (lane == 3'd7) begin
              state       <= ST_MIX;
              ready_q     <= 1'b0;
              round_count <= round_count + 32'd1;
            end
          end
        end
        default: state <= ST_MIX;
      endcase
    end
  end

  // Error bookkeeping; a mismatch in the same cycle as clr lands after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count       <= '0;
      err_flag        <= 1'b0;
      first_err_round <= 32'd0;
      first_err_lane  <= 3'd0;
    end else if (mism) begin
      if (clr) begin
        err_count <= ERR_W'(1);
      end else if (err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + ERR_W'(1);
      end
      if (clr || !err_flag) begin
        first_err_round <= round_count;
        first_err_lane  <= lane;
      end
      err_flag <= 1'b1;
    end else if (clr) begin
      err_count       <= '0;
      err_flag        <= 1'b0;
      first_err_round <= 32'd0;
      first_err_lane  <= 3'd0;
    end
  end

endmodule

// File: tb/tb_mix_stream_checker.sv
// Bench for mix_stream_checker: a round-level model of the expected stream and
// error bookkeeping, checked every cycle, plus directed scenarios with literal results.
module tb_mix_stream_checker;

  typedef logic [7:0][31:0] lanes_t;

  localparam lanes_t ROUND0 = {32'h00BE02B0, 32'h008801EF, 32'h005B012F, 32'h018100C8,
                               32'h00C40066, 32'h006E0039, 32'h0033001D, 32'h001A0011};
  localparam logic [31:0] MUL_T [8] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam logic [31:0] ADD_T [8] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr   = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] data  = 32'd0;

  always #5 clk = ~clk;

  mix_stream_checker_if if_a ();
  mix_stream_checker_if if_b ();
  assign if_a.in_valid = valid;
  assign if_a.in_data  = data;
  assign if_b.in_valid = valid;
  assign if_b.in_data  = data;

  logic [15:0] cnt_a;
  logic        flag_a;
  logic [31:0] fr_a;
  logic [2:0]  fl_a;
  logic [31:0] rc_a;
  logic [1:0]  cnt_b;
  logic        flag_b;
  logic [31:0] fr_b;
  logic [2:0]  fl_b;
  logic [31:0] rc_b;

  mix_stream_checker #(.ERR_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .stream(if_a), .clr(clr),
    .err_count(cnt_a), .err_flag(flag_a), .first_err_round(fr_a),
    .first_err_lane(fl_a), .round_count(rc_a)
  );

  mix_stream_checker #(.ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .stream(if_b), .clr(clr),
    .err_count(cnt_b), .err_flag(flag_b), .first_err_round(fr_b),
    .first_err_lane(fl_b), .round_count(rc_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected lane values of the next round, straight from the mixing rules.
  function automatic lanes_t mix_round(input lanes_t v);
    lanes_t r;
    r = v;
    for (int i = 0; i < 8; i++) r[i] = r[i] + r[(i + 7) % 8];
    for (int i = 0; i < 8; i++) r[i] = r[i] ^ (r[(i + 3) % 8] << 16);
    for (int i = 0; i < 8; i++) r[i] = r[i] * MUL_T[i] + ADD_T[i];
    return r;
  endfunction

  function automatic lanes_t seed_lanes();
    lanes_t r;
    for (int i = 0; i < 8; i++) r[i] = 32'(i);
    return r;
  endfunction

  // Model state.
  lanes_t      m_words;
  int          m_lane;
  int          m_wait;
  bit          m_ready;
  logic [31:0] m_round;
  int          m_cnt_a;
  int          m_cnt_b;
  bit          m_flag;
  logic [31:0] m_fr;
  logic [2:0]  m_fl;
  bit          cmp_en = 1'b0;

  task automatic model_reset();
    m_words = mix_round(seed_lanes());
    m_lane  = 0;
    m_wait  = 24;
    m_ready = 1'b0;
    m_round = 32'd0;
    m_cnt_a = 0;
    m_cnt_b = 0;
    m_flag  = 1'b0;
    m_fr    = 32'd0;
    m_fl    = 3'd0;
  endtask

  task automatic model_step();
    bit hs;
    bit mm;
    hs = valid && m_ready;
    mm = hs && (data != m_words[m_lane]);
    if (clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
      m_flag  = 1'b0;
      m_fr    = 32'd0;
      m_fl    = 3'd0;
    end
    if (mm) begin
      if (!m_flag) begin
        m_fr = m_round;
        m_fl = 3'(m_lane);
      end
      m_flag  = 1'b1;
      m_cnt_a = (m_cnt_a < 65535) ? m_cnt_a + 1 : 65535;
      m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
    end
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_ready = 1'b1;
    end else if (hs) begin
      if (m_lane == 7) begin
        m_lane  = 0;
        m_round = m_round + 32'd1;
        m_words = mix_round(m_words);
        m_wait  = 24;
        m_ready = 1'b0;
      end else begin
        m_lane++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of both checkers against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("ready_a", 64'(if_a.in_ready), 64'(m_ready));
        check("ready_b", 64'(if_b.in_ready), 64'(m_ready));
        check("err_count_a", 64'(cnt_a), 64'(m_cnt_a));
        check("err_count_b", 64'(cnt_b), 64'(m_cnt_b));
        check("err_flag_a", 64'(flag_a), 64'(m_flag));
        check("err_flag_b", 64'(flag_b), 64'(m_flag));
        check("first_round_a", 64'(fr_a), 64'(m_fr));
        check("first_round_b", 64'(fr_b), 64'(m_fr));
        check("first_lane_a", 64'(fl_a), 64'(m_fl));
        check("first_lane_b", 64'(fl_b), 64'(m_fl));
        check("round_count_a", 64'(rc_a), 64'(m_round));
        check("round_count_b", 64'(rc_b), 64'(m_round));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Stimulus helpers; all are entered and left 1 time unit after a rising edge.
  task automatic check_reset_values(input string tag);
    check({tag, "_ready_a"}, 64'(if_a.in_ready), 64'(0));
    check({tag, "_ready_b"}, 64'(if_b.in_ready), 64'(0));
    check({tag, "_count_a"}, 64'(cnt_a), 64'(0));
    check({tag, "_count_b"}, 64'(cnt_b), 64'(0));
    check({tag, "_flag_a"}, 64'(flag_a), 64'(0));
    check({tag, "_fround_a"}, 64'(fr_a), 64'(0));
    check({tag, "_flane_a"}, 64'(fl_a), 64'(0));
    check({tag, "_round_a"}, 64'(rc_a), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    valid = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] d, input bit c, input int gap);
    bit hs;
    int n;
    valid = 1'b0;
    clr   = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    valid = 1'b1;
    data  = d;
    clr   = c;
    hs    = 1'b0;
    n     = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = if_a.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) check("handshake_timeout", 64'(0), 64'(1));
    clr = 1'b0;
  endtask

  task automatic send_round(input lanes_t w, input int max_gap);
    for (int i = 0; i < 8; i++) send(w[i], 1'b0, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    valid = 1'b0;
  endtask

  task automatic count_low(input string name);
    int n;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (if_a.in_ready) break;
      n++;
    end
    check(name, 64'(n), 64'(24));
    @(posedge clk);
    #1;
  endtask

  lanes_t r0_lit;
  lanes_t r0_mod;
  lanes_t r1_mod;
  lanes_t w;

  initial begin
    r0_lit = ROUND0;
    r0_mod = mix_round(seed_lanes());
    r1_mod = mix_round(r0_mod);
    for (int i = 0; i < 8; i++)
      check($sformatf("model_round0_lane%0d", i), 64'(r0_mod[i]), 64'(r0_lit[i]));

    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cmp_en = 1'b1;

    // Clean round 0 with in_valid held high.
    do_reset("t1_rst");
    send_round(r0_lit, 0);
    count_low("t1_ready_low_after_lane7");
    check("t1_err_count", 64'(cnt_a), 64'(0));
    check("t1_err_flag", 64'(flag_a), 64'(0));
    check("t1_round_count", 64'(rc_a), 64'(1));

    // Two mismatches; the first one is the one recorded.
    do_reset("t2_rst");
    w    = r0_lit;
    w[5] = 32'h005B0130;
    w[6] = 32'h00000000;
    send_round(w, 0);
    check("t2_err_count", 64'(cnt_a), 64'(2));
    check("t2_err_flag", 64'(flag_a), 64'(1));
    check("t2_first_lane", 64'(fl_a), 64'(5));
    check("t2_first_round", 64'(fr_a), 64'(0));

    // Gapped stream for round 0, then round 1 from the model.
    do_reset("t3_rst");
    send_round(r0_lit, 5);
    check("t3_r0_err_count", 64'(cnt_a), 64'(0));
    check("t3_r0_round_count", 64'(rc_a), 64'(1));
    send_round(r1_mod, 5);
    check("t3_r1_err_count", 64'(cnt_a), 64'(0));
    check("t3_r1_round_count", 64'(rc_a), 64'(2));

    // Reset in the middle of CMP after one mismatch.
    do_reset("t4_rst");
    send(r0_lit[0], 1'b0, 0);
    send(~r0_lit[1], 1'b0, 0);
    send(r0_lit[2], 1'b0, 0);
    valid = 1'b0;
    @(posedge clk);
    #1;
    check("t4_pre_err_count", 64'(cnt_a), 64'(1));
    check("t4_pre_first_lane", 64'(fl_a), 64'(1));
    rst_n = 1'b0;
    #1;
    check_reset_values("t4_async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_low("t4_ready_low_after_release");
    send_round(r0_lit, 0);
    check("t4_err_count", 64'(cnt_a), 64'(0));
    check("t4_round_count", 64'(rc_a), 64'(1));

    // Saturation at ERR_W=2, then clr colliding with a mismatch.
    do_reset("t5_rst");
    for (int i = 0; i < 5; i++) send(~r0_lit[i], 1'b0, 0);
    send(r0_lit[5], 1'b0, 0);
    check("t5_sat_count_b", 64'(cnt_b), 64'(3));
    check("t5_count_a", 64'(cnt_a), 64'(5));
    check("t5_first_lane_b", 64'(fl_b), 64'(0));
    send(~r0_lit[6], 1'b1, 0);
    check("t5_clr_count_b", 64'(cnt_b), 64'(1));
    check("t5_clr_count_a", 64'(cnt_a), 64'(1));
    check("t5_clr_flag_b", 64'(flag_b), 64'(1));
    check("t5_clr_first_lane_b", 64'(fl_b), 64'(6));
    check("t5_clr_first_round_b", 64'(fr_b), 64'(0));
    send(r0_lit[7], 1'b0, 0);
    valid = 1'b0;
    clr   = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("t5_plain_clr_count_a", 64'(cnt_a), 64'(0));
    check("t5_plain_clr_flag_a", 64'(flag_a), 64'(0));
    check("t5_plain_clr_first_lane_a", 64'(fl_a), 64'(0));
    check("t5_plain_clr_round_a", 64'(rc_a), 64'(1));

    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mix_stream_checker.md
# mix_stream_checker

Receive-side checker for the eight-lane 32-bit mixing workload. It regenerates the expected lane values round by round from a fixed seed, using an iterative one-operation-per-cycle engine. It consumes the producer's lane words over a valid/ready stream and counts and localises mismatches. It sits at the sink end of the mixer's output stream in simulator-benchmark builds.

## Interface
- ERR_W, 16, width of the saturating mismatch counter (≥1)
- clk  in  1  rising-edge clock, sole clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a lane word on in_data
- in_data  in  32  lane word; lanes arrive in order 0..7 each round
- in_ready  out  1  checker accepts a word this cycle
- clr  in  1  synchronous clear of err_count/err_flag/first_err_*
- err_count  out  ERR_W  saturating count of mismatching words
- err_flag  out  1  sticky: at least one mismatch since reset/clr
- first_err_round  out  32  round_count value at first mismatch
- first_err_lane  out  3  lane index of first mismatch
- round_count  out  32  completed rounds, wraps 2^32-1 → 0

## Operation
- State s[0..7], 32 bits each, seeded s[i]=i on reset.
- One round has three phases, each run lane by lane for i=0..7, in place. Later lanes see values already updated earlier in the same phase. All arithmetic is mod 2^32.
  - A: s[i] = s[i] + s[(i+7)%8]
  - B: s[i] = s[i] ^ (s[(i+3)%8] << 16)
  - C: s[i] = s[i]*M[i] + K[i], with M={2,3,5,7,11,13,17,19} and K={3,5,7,11,13,17,19,23}
- FSM states:
  - MIX: phase counter 0..2 and lane counter 0..7, one update per cycle, 24 cycles total. After phase C, lane 7, go to CMP with lane counter 0.
  - CMP: in_ready=1. Each handshake (in_valid & in_ready) compares in_data with s[lane], then increments lane.
  - Leaving CMP: the handshake on lane 7 sends the FSM to MIX and increments round_count.
- Received data never modifies s. The expected stream continues regardless of mismatches.
- On a mismatch:
  - err_count increments, saturating at 2^ERR_W-1.
  - If err_flag was 0, capture first_err_round=round_count and first_err_lane=lane, and set err_flag.
- clr:
  - Zeroes err_count, err_flag and first_err_*. It does not touch s, the FSM or round_count.
  - If a mismatch occurs in the same cycle as clr, the mismatch is applied after the clear: err_count=1, err_flag=1, and first_err_* take the current values.
- Reset, any time including mid-MIX or mid-CMP: s is re-seeded, the FSM goes to MIX at phase 0 / lane 0, and all outputs return to reset values.

## Timing
- Reset values: in_ready=0, err_count=0, err_flag=0, first_err_round=0, first_err_lane=0, round_count=0.
- From rst_n deassert, the first in_ready=1 is at cycle 24 (cycles counted from 0 at the first rising edge after deassert).
- in_ready is a registered function of the FSM state only. It does not depend on in_valid.
- A word is consumed only on a cycle where in_valid=1 and in_ready=1. Idle cycles in CMP do not advance the lane.
- The in_data comparison happens at the handshake edge. err_count, err_flag and first_err_* are visible the next cycle.
- After the lane-7 handshake, in_ready=0 on the next cycle and stays 0 for exactly 24 cycles.
- Minimum period is 32 cycles per round (24 MIX + 8 CMP with in_valid held high).

## Test plan
- Reset, then stream round 0 with in_valid high: 001A0011, 0033001D, 006E0039, 00C40066, 018100C8, 005B012F, 008801EF, 00BE02B0 (hex). Required: err_count=0, err_flag=0, round_count=1, in_ready low for 24 cycles after the lane-7 handshake.
- Same stimulus with lane 5 as 005B0130 and lane 6 as 0. Required: err_count=2, err_flag=1, first_err_lane=5, first_err_round=0; the lane-6 mismatch does not overwrite first_err_*.
- Round 0 words with random in_valid gaps of 0–5 cycles. Required: the same result as the first test and no lane skipped or duplicated. Then send 8 round-1 words taken from a model. Required: err_count=0, round_count=2.
- Assert rst_n low after 3 round-0 handshakes, including one mismatch. Required: all outputs return to reset values immediately, in_ready stays low for 24 cycles after release, and round-0 values again pass cleanly.
- With ERR_W=2, send 5 mismatching words. Required: err_count=3, held at saturation. Then pulse clr on the same cycle as a mismatch. Required: err_count=1, err_flag=1, and first_err_* updated to that handshake.
